// File: rtl/phase_unwrap_freq.sv
// phase_unwrap_freq: unwraps a wrapped two's-complement phase stream into an
// accumulated phase, and estimates frequency as the moving average of the
// per-sample phase increment over 2^AVG_LOG2 samples.
//
// Latency: a sample accepted at edge t is reflected in unwrapped_out at the
// same edge (visible in the following cycle). The window sum also registers
// there, and freq_out registers one edge later.

package phase_unwrap_freq_pkg;

  // Width of the phase input and of the frequency output.
  parameter int DEFAULT_SIZE_DATA = 16;

  // IDLE: no previous sample; FILL: averaging window not yet full; RUN: steady state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

module phase_unwrap_freq
  import phase_unwrap_freq_pkg::*;
#(
  parameter int SIZE_DATA = DEFAULT_SIZE_DATA,
  parameter int AVG_LOG2  = 3,
  parameter int SIZE_ACC  = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic signed [SIZE_DATA-1:0] phase_in,
  input  logic                        phase_valid,
  output logic signed [SIZE_ACC-1:0]  unwrapped_out,
  output logic                        unwrapped_valid,
  output logic signed [SIZE_DATA-1:0] freq_out,
  output logic                        freq_valid
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = SIZE_DATA + AVG_LOG2;

  localparam logic [AVG_LOG2-1:0] PTR_ONE   = AVG_LOG2'(1);
  localparam logic [AVG_LOG2-1:0] FILL_LAST = AVG_LOG2'(N - 1);

  // Reject parameter combinations the datapath is not sized for.
  if (AVG_LOG2 < 1 || AVG_LOG2 > 6) begin : g_bad_avg_log2
    $error("phase_unwrap_freq: AVG_LOG2 must be in 1..6");
  end
  if (SIZE_ACC < SIZE_DATA) begin : g_bad_size_acc
    $error("phase_unwrap_freq: SIZE_ACC must be >= SIZE_DATA");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                      state_q, state_d;
  logic signed [SIZE_DATA-1:0] prev_q, prev_d;
  logic signed [SIZE_ACC-1:0]  acc_q, acc_d;
  logic signed [SW-1:0]        sum_q, sum_d;
  logic [AVG_LOG2-1:0]         wptr_q, wptr_d;
  logic [AVG_LOG2-1:0]         fill_cnt_q, fill_cnt_d;
  logic                        unw_valid_q, unw_valid_d;
  // Window sum was updated with a full window last edge: freq_out is due.
  logic                        sum_valid_q, sum_valid_d;
  logic signed [SIZE_DATA-1:0] freq_q, freq_d;
  logic                        freq_valid_q, freq_valid_d;

  // Circular buffer of the last N increments.
  logic signed [SIZE_DATA-1:0] hist_q [N];
  logic                        hist_we;

  // Flush discards a coincident sample; reset also clears via the same path.
  logic accept;
  logic clear;
  assign accept = phase_valid && !flush;
  assign clear  = reset || flush;

  // Phase increment. Modulo-2^SIZE_DATA subtraction performs the +/-pi unwrap;
  // an increment of exactly -2^(SIZE_DATA-1) naturally lands on -pi.
  logic signed [SIZE_DATA-1:0] diff;
  assign diff = phase_in - prev_q;

  // Window sum update: add the newest increment, drop the one being overwritten.
  // Buffer slots start at zero, so while filling the sum is simply the running total.
  logic signed [SW-1:0] sum_next;
  assign sum_next = sum_q + SW'(diff) - SW'(hist_q[wptr_q]);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  // Computes the next value of every register from the current state and the accepted sample.
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves one
    // unassigned would infer a latch.
    state_d      = state_q;
    prev_d       = prev_q;
    acc_d        = acc_q;
    sum_d        = sum_q;
    wptr_d       = wptr_q;
    fill_cnt_d   = fill_cnt_q;
    unw_valid_d  = 1'b0;
    sum_valid_d  = 1'b0;
    hist_we      = 1'b0;
    freq_d       = freq_q;
    freq_valid_d = 1'b0;

    // Second pipeline stage: scale the registered window sum (floor division by N).
    if (sum_valid_q) begin
      freq_d       = SIZE_DATA'(sum_q >>> AVG_LOG2);
      freq_valid_d = 1'b1;
    end

    if (accept) begin
      prev_d      = phase_in;
      unw_valid_d = 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          // First sample after restart only primes prev and the accumulator.
          acc_d      = SIZE_ACC'(phase_in);
          fill_cnt_d = '0;
          state_d    = ST_FILL;
        end
        ST_FILL: begin
          acc_d      = acc_q + SIZE_ACC'(diff);
          sum_d      = sum_next;
          hist_we    = 1'b1;
          wptr_d     = wptr_q + PTR_ONE;
          fill_cnt_d = fill_cnt_q + PTR_ONE;
          // The N-th increment completes the window.
          if (fill_cnt_q == FILL_LAST) begin
            state_d     = ST_RUN;
            sum_valid_d = 1'b1;
          end
        end
        ST_RUN: begin
          acc_d       = acc_q + SIZE_ACC'(diff);
          sum_d       = sum_next;
          hist_we     = 1'b1;
          wptr_d      = wptr_q + PTR_ONE;
          sum_valid_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // FSM state register; reset and flush both restart from IDLE.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; reset and flush clear everything, including pending valids.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, regardless of statement order.
    if (clear) begin
      prev_q       <= '0;
      acc_q        <= '0;
      sum_q        <= '0;
      wptr_q       <= '0;
      fill_cnt_q   <= '0;
      unw_valid_q  <= 1'b0;
      sum_valid_q  <= 1'b0;
      freq_q       <= '0;
      freq_valid_q <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      acc_q        <= acc_d;
      sum_q        <= sum_d;
      wptr_q       <= wptr_d;
      fill_cnt_q   <= fill_cnt_d;
      unw_valid_q  <= unw_valid_d;
      sum_valid_q  <= sum_valid_d;
      freq_q       <= freq_d;
      freq_valid_q <= freq_valid_d;
    end
  end

  // Increment history; overwrites the oldest entry at the write pointer.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is cleared on restart because the window sum subtracts the
    // overwritten entry; stale contents would corrupt the first N averages.
    if (clear) begin
      for (int i = 0; i < N; i++) begin
        hist_q[i] <= '0;
      end
    end else if (hist_we) begin
      hist_q[wptr_q] <= diff;
    end
  end

  assign unwrapped_out   = acc_q;
  assign unwrapped_valid = unw_valid_q;
  assign freq_out        = freq_q;
  assign freq_valid      = freq_valid_q;

endmodule
